// File: rtl/step_sequencer_pkg.sv
// Shared state encoding and default timing for the step/dir sequencer axes.
package step_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StHigh  = 2'd2,
    StLow   = 2'd3
  } seq_state_e;

  // 25 MHz clock: 1 us dir setup, 2 us high, 2 us low.
  localparam int unsigned DefDirSetupCyc  = 25;
  localparam int unsigned DefPulseHighCyc = 50;
  localparam int unsigned DefPulseLowCyc  = 50;
  localparam int unsigned DefPendW        = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned timer_width(input int unsigned max_cyc);
    return (max_cyc < 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage

// File: rtl/step_sequencer_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module step_sequencer_pulse_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// Accumulates signed step requests and replays them as driver-legal step/dir waveforms.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned DIR_SETUP_CYC  = DefDirSetupCyc,
  parameter int unsigned PULSE_HIGH_CYC = DefPulseHighCyc,
  parameter int unsigned PULSE_LOW_CYC  = DefPulseLowCyc,
  parameter int unsigned PEND_W         = DefPendW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              step_req,
  input  logic              step_dir,
  input  logic              flush,
  input  logic              clear_ovf,
  output logic              step_out,
  output logic              dir_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned TimerW =
      timer_width(max3(DIR_SETUP_CYC, PULSE_HIGH_CYC, PULSE_LOW_CYC));
  // Timer counts down to zero, so each state lasts load value + 1 cycles.
  localparam logic [TimerW-1:0] SetupLoad = TimerW'(DIR_SETUP_CYC - 1);
  localparam logic [TimerW-1:0] HighLoad  = TimerW'(PULSE_HIGH_CYC - 1);
  localparam logic [TimerW-1:0] LowLoad   = TimerW'(PULSE_LOW_CYC - 1);

  localparam logic signed [PEND_W:0] One      = (PEND_W + 1)'(1);
  localparam logic signed [PEND_W:0] MinusOne = (PEND_W + 1)'(-1);
  localparam logic signed [PEND_W:0] PendMax  = (PEND_W + 1)'(2 ** (PEND_W - 1) - 1);
  localparam logic signed [PEND_W:0] PendMin  = -PendMax;

  seq_state_e        state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic              dir_d, step_d;
  logic              tmr_load, tmr_done;
  logic [TimerW-1:0] tmr_val;
  logic              cons_fwd, cons_rev;
  logic              pend_nz, want_fwd;

  assign pend_nz  = (pending_q != '0);
  assign want_fwd = ~pending_q[PEND_W-1];

  step_sequencer_pulse_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_out;
    step_d   = step_out;
    tmr_load = 1'b0;
    tmr_val  = '0;
    cons_fwd = 1'b0;
    cons_rev = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && pend_nz && !flush) begin
          tmr_load = 1'b1;
          if (dir_out == want_fwd) begin
            state_d  = StHigh;
            step_d   = 1'b1;
            tmr_val  = HighLoad;
            cons_fwd = want_fwd;
            cons_rev = ~want_fwd;
          end else begin
            state_d = StSetup;
            dir_d   = want_fwd;
            tmr_val = SetupLoad;
          end
        end
      end
      StSetup: begin
        if (!enable || flush) begin
          state_d = StIdle;
        end else if (tmr_done) begin
          if (!pend_nz) begin
            state_d = StIdle;
          end else if (dir_out != want_fwd) begin
            // Requests reversed the sign while settling: restart setup the other way.
            dir_d    = want_fwd;
            tmr_load = 1'b1;
            tmr_val  = SetupLoad;
          end else begin
            state_d  = StHigh;
            step_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = HighLoad;
            cons_fwd = want_fwd;
            cons_rev = ~want_fwd;
          end
        end
      end
      StHigh: begin
        if (tmr_done) begin
          state_d  = StLow;
          step_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LowLoad;
        end
      end
      StLow: begin
        if (tmr_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic signed [PEND_W:0] pend_ext, cons_delta, req_delta, base_sum, full_sum;
  logic                   req_act, drop;

  always_comb begin
    req_act    = step_req && !flush;
    pend_ext   = {pending_q[PEND_W-1], pending_q};
    cons_delta = cons_fwd ? MinusOne : (cons_rev ? One : '0);
    req_delta  = !req_act ? '0 : (step_dir ? One : MinusOne);
    base_sum   = pend_ext + cons_delta;
    full_sum   = base_sum + req_delta;
    // Consume always moves toward zero, so only the request can push past the limit.
    drop       = req_act && ((full_sum > PendMax) || (full_sum < PendMin));
    if (flush) begin
      pending_d = '0;
    end else if (drop) begin
      pending_d = base_sum[PEND_W-1:0];
    end else begin
      pending_d = full_sum[PEND_W-1:0];
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      step_out  <= 1'b0;
      dir_out   <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_out  <= step_d;
      dir_out   <= dir_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign pending  = pending_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: stimulus pushes expected pulse directions, monitor checks them.
`timescale 1ns/1ps
module tb_step_sequencer;

  localparam int SETUP = 25;
  localparam int HIGH  = 50;
  localparam int LOW   = 50;
  localparam int PER   = HIGH + LOW + 1;

  logic       clk, rst_n, enable, step_req, step_dir, flush, clear_ovf;
  logic       step_out, dir_out, busy, overflow;
  logic [7:0] pending;
  logic       en4, req4, clr4;
  logic       step4, dirout4, busy4, ovf4;
  logic [3:0] pend4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int count4 = 0;
  bit mon_en = 0;
  bit exp_q[$];

  step_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_req(step_req), .step_dir(step_dir),
    .flush(flush), .clear_ovf(clear_ovf), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .pending(pending), .overflow(overflow)
  );

  step_sequencer #(.PEND_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .step_req(req4), .step_dir(1'b1),
    .flush(1'b0), .clear_ovf(clr4), .step_out(step4), .dir_out(dirout4),
    .busy(busy4), .pending(pend4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input bit d);
    step_req = 1'b1;
    step_dir = d;
    tick();
    step_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || pending != 8'd0) && n < max) begin
      tick();
      n++;
    end
    check("settle_in_time", int'(n < max), 1);
  endtask

  task automatic wait_rise(input int max, output int t);
    int n = 0;
    while (step_out && n < max) begin tick(); n++; end
    while (!step_out && n < max) begin tick(); n++; end
    t = cyc;
    check("rise_in_time", int'(n < max), 1);
  endtask

  // Monitor: each step_out rise must match the oldest expected direction and obey timing.
  initial begin
    bit prev_step, prev_dir, exp_dir;
    int high_cnt, low_cnt, dir_age;
    prev_step = 0; prev_dir = 0; high_cnt = 0; low_cnt = 1000; dir_age = 1000;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_step = 0; high_cnt = 0; low_cnt = 1000; dir_age = 1000; prev_dir = dir_out;
      end else begin
        if (step_out && !prev_step) begin
          check("pulse_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_dir = exp_q.pop_front();
            check("pulse_dir", dir_out, exp_dir);
          end
          check("dir_setup_met", int'(dir_out == prev_dir && dir_age >= SETUP), 1);
          check("low_gap_met", int'(low_cnt >= LOW), 1);
          high_cnt = 1;
        end else if (step_out) begin
          check("dir_stable_high", dir_out, prev_dir);
          high_cnt++;
        end else if (prev_step) begin
          check("pulse_high_width", high_cnt, HIGH);
          low_cnt = 1;
        end else if (low_cnt < 1000) begin
          low_cnt++;
        end
        if (dir_out != prev_dir) dir_age = 1;
        else if (dir_age < 1000) dir_age++;
        prev_dir  = dir_out;
        prev_step = step_out;
      end
    end
  end

  initial begin
    bit p4 = 0;
    forever begin
      @(negedge clk);
      if (step4 && !p4) count4++;
      p4 = step4;
    end
  end

  initial begin
    int t0, t1, t2, mp, np, n, p4m;
    bit movf, ovf4m;
    rst_n = 1'b0; enable = 1'b1; step_req = 1'b0; step_dir = 1'b0; flush = 1'b0;
    clear_ovf = 1'b0; en4 = 1'b0; req4 = 1'b0; clr4 = 1'b0;
    do_reset();
    check("rst_step", step_out, 0);
    check("rst_dir", dir_out, 0);
    check("rst_pending", int'($signed(pending)), 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // Reset in the middle of a high pulse.
    req(1'b0);
    tick();
    check("t1_high_started", step_out, 1);
    repeat (10) tick();
    #5 rst_n = 1'b0;
    #1;
    check("t1_async_drop", step_out, 0);
    check("t1_async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single reverse request, no dir change.
    exp_q.push_back(1'b0);
    req(1'b0);
    check("t2_pending", int'($signed(pending)), -1);
    tick();
    check("t2_rise", step_out, 1);
    check("t2_consumed", int'($signed(pending)), 0);
    repeat (PER - 2) tick();
    check("t2_busy_before_end", busy, 1);
    tick();
    check("t2_busy_fall", busy, 0);

    // Forward then reverse during SETUP: cancelled, no pulse.
    do_reset();
    req(1'b1);
    repeat (4) tick();
    req(1'b0);
    check("t6_pending", int'($signed(pending)), 0);
    check("t6_in_setup", busy, 1);
    check("t6_dir", dir_out, 1);
    repeat (SETUP - 5) tick();
    check("t6_setup_last", busy, 1);
    tick();
    check("t6_idle", busy, 0);
    check("t6_dir_kept", dir_out, 1);

    // Forward request with dir change.
    do_reset();
    exp_q.push_back(1'b1);
    req(1'b1);
    check("t3_pending", int'($signed(pending)), 1);
    check("t3_dir_old", dir_out, 0);
    tick();
    check("t3_dir_new", dir_out, 1);
    check("t3_no_step", step_out, 0);
    repeat (SETUP - 1) tick();
    check("t3_pre_rise", step_out, 0);
    tick();
    check("t3_rise", step_out, 1);
    wait_idle(3 * PER);

    // Three consecutive forward requests, dir already forward.
    repeat (3) exp_q.push_back(1'b1);
    req(1'b1);
    req(1'b1);
    check("t4_first_rise", step_out, 1);
    t0 = cyc;
    req(1'b1);
    check("t4_pending", int'($signed(pending)), 2);
    wait_rise(2 * PER, t1);
    check("t4_period1", t1 - t0, PER);
    wait_rise(2 * PER, t2);
    check("t4_period2", t2 - t1, PER);
    wait_idle(2 * PER);
    check("t4_queue_drained", exp_q.size(), 0);

    // Randomized accumulate-then-release phases against an integer model.
    mp = 0; movf = 0;
    for (int ph = 0; ph < 6; ph++) begin
      enable = 1'b0;
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        bit d, fl;
        d  = 1'($urandom_range(0, 1));
        fl = ($urandom_range(0, 9) == 0);
        flush = fl;
        req(d);
        flush = 1'b0;
        if (fl) mp = 0;
        else begin
          np = mp + (d ? 1 : -1);
          if (np > 127 || np < -127) movf = 1; else mp = np;
        end
        repeat ($urandom_range(0, 2)) tick();
      end
      check("rand_pending", int'($signed(pending)), mp);
      check("rand_overflow", overflow, movf);
      for (int i = 0; i < ((mp < 0) ? -mp : mp); i++) exp_q.push_back(mp > 0);
      enable = 1'b1;
      wait_idle(((mp < 0) ? -mp : mp) * PER + 4 * SETUP);
      check("rand_drained", int'($signed(pending)), 0);
      check("rand_queue_empty", exp_q.size(), 0);
      mp = 0;
    end

    // Saturation at +127, drop beats clear_ovf, then flush.
    enable = 1'b0;
    step_req = 1'b1; step_dir = 1'b1;
    repeat (130) begin
      tick();
      if (mp + 1 > 127) movf = 1; else mp = mp + 1;
    end
    step_req = 1'b0;
    check("sat_pending", int'($signed(pending)), mp);
    check("sat_overflow", overflow, movf);
    clear_ovf = 1'b1;
    req(1'b1);
    check("sat_drop_wins", overflow, 1);
    tick();
    clear_ovf = 1'b0;
    check("sat_cleared", overflow, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_flushed", int'($signed(pending)), 0);

    // PEND_W=4 instance: saturate with enable low, clear, then release.
    p4m = 0; ovf4m = 0;
    req4 = 1'b1;
    repeat (9) begin
      tick();
      if (p4m + 1 > 7) ovf4m = 1; else p4m = p4m + 1;
    end
    req4 = 1'b0;
    tick();
    check("w4_pending", int'($signed(pend4)), p4m);
    check("w4_overflow", ovf4, ovf4m);
    check("w4_no_pulses", count4, 0);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    check("w4_ovf_cleared", ovf4, 0);
    en4 = 1'b1;
    n = 0;
    while ((busy4 || pend4 != 4'd0) && n < p4m * PER + 4 * SETUP) begin
      tick();
      n++;
    end
    tick();
    check("w4_pulse_count", count4, p4m);
    check("w4_drained", int'($signed(pend4)), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
